// File: rtl/lab1_imul_int_mul_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : lab1_imul_accum_pkg
//  Brief   : Shared state encoding and counter sizing for the product
//            accumulator (reduction half of the dot-product pipeline).
//  Rev     : 1.0  initial release
// ============================================================================
package lab1_imul_accum_pkg;

  // Two-state control: gather products, then present the group sum.
  localparam logic [0:0] STATE_ACCUM = 1'b0;
  localparam logic [0:0] STATE_SEND  = 1'b1;

  // Group counter width; a single-product group still needs a 1-bit counter.
  function automatic int cnt_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lab1_imul_int_mul_accum_if.sv
`default_nettype none
// ============================================================================
//  Module  : lab1_imul_int_mul_accum_if
//  Brief   : Product-in / sum-out val/rdy stream bundle for the accumulator.
//            slave = accumulator side, master = producer/consumer side.
//  Rev     : 1.0  initial release
// ============================================================================
interface lab1_imul_int_mul_accum_if #(
  parameter int p_nbits = 32
);
  logic               istream_val;
  logic               istream_rdy;
  logic [p_nbits-1:0] istream_msg;
  logic               ostream_val;
  logic               ostream_rdy;
  logic [p_nbits-1:0] ostream_msg;

  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg
  );

  modport master (
    output istream_val, istream_msg, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg
  );
endinterface
`default_nettype wire

// File: rtl/lab1_imul_int_mul_accum_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : lab1_imul_int_mul_accum_ctrl
//  Brief   : ACCUM/SEND control FSM and product counter for the accumulator.
//            Produces the stream ready/valid and the accumulator enables.
//  Rev     : 1.0  initial release
// ============================================================================
module lab1_imul_int_mul_accum_ctrl #(
  parameter int p_len = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_istream_val,
  input  wire logic i_ostream_rdy,
  output logic      o_istream_rdy,
  output logic      o_ostream_val,
  output logic      o_acc_en,
  output logic      o_acc_clr
);
  import lab1_imul_accum_pkg::*;

  localparam int                 c_CNT_W    = cnt_width(p_len);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(p_len - 1);

  logic [0:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_last;

  assign w_last = (r_cnt == c_CNT_LAST);

  // Handshake outputs depend on state only; enables qualify the datapath so
  // the accumulator never samples istream_msg without a real transfer.
  always_comb begin
    o_istream_rdy = (r_state == STATE_ACCUM);
    o_ostream_val = (r_state == STATE_SEND);
    o_acc_en      = o_istream_rdy && i_istream_val;
    o_acc_clr     = o_ostream_val && i_ostream_rdy;
  end

  // State and count advance only on handshakes; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= STATE_ACCUM;
      r_cnt   <= '0;
    end else if (r_state == STATE_ACCUM) begin
      if (o_acc_en) begin
        if (w_last) begin
          r_cnt   <= '0;
          r_state <= STATE_SEND;
        end else begin
          r_cnt   <= r_cnt + c_CNT_W'(1);
        end
      end
    end else begin
      if (i_ostream_rdy) begin
        r_state <= STATE_ACCUM;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lab1_imul_int_mul_accum.sv
`default_nettype none
// ============================================================================
//  Module  : lab1_imul_int_mul_accum
//  Brief   : Sums groups of p_len consecutive products (mod 2^p_nbits) and
//            emits one registered sum per group on a val/rdy stream.
//  Rev     : 1.0  initial release
// ============================================================================
module lab1_imul_int_mul_accum #(
  parameter int p_nbits = 32,
  parameter int p_len   = 4
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  lab1_imul_int_mul_accum_if.slave  io
);

  logic [p_nbits-1:0] r_acc;
  logic [p_nbits-1:0] w_sum;
  logic               w_acc_en;
  logic               w_acc_clr;

  lab1_imul_int_mul_accum_ctrl #(
    .p_len (p_len)
  ) u_ctrl (
    .clk           (clk),
    .reset         (reset),
    .i_istream_val (io.istream_val),
    .i_ostream_rdy (io.ostream_rdy),
    .o_istream_rdy (io.istream_rdy),
    .o_ostream_val (io.ostream_val),
    .o_acc_en      (w_acc_en),
    .o_acc_clr     (w_acc_clr)
  );

  // Carry out of the top bit is dropped: sums wrap silently.
  assign w_sum = r_acc + io.istream_msg;

  // Accumulator clears when the sum is taken and adds only on an input
  // handshake; the two never coincide since they belong to different states.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_acc_clr) begin
      r_acc <= '0;
    end else if (w_acc_en) begin
      r_acc <= w_sum;
    end
  end

  assign io.ostream_msg = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_lab1_imul_int_mul_accum.sv
`default_nettype none
// ============================================================================
//  Module  : tb_lab1_imul_int_mul_accum
//  Brief   : Self-checking bench for the product accumulator (p_len=4 and
//            p_len=1 instances), table-driven groups plus directed sequences.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_lab1_imul_int_mul_accum;

  typedef struct {
    logic [3:0][31:0] din;
    logic [31:0]      exp;
    bit               gaps;
    string            name;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lab1_imul_int_mul_accum_if #(.p_nbits(32)) if4 ();
  lab1_imul_int_mul_accum_if #(.p_nbits(32)) if1 ();

  lab1_imul_int_mul_accum #(.p_nbits(32), .p_len(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .io    (if4)
  );

  lab1_imul_int_mul_accum #(.p_nbits(32), .p_len(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .io    (if1)
  );

  int n_pass  = 0;
  int n_total = 0;

  int          out4_cnt = 0;
  logic [31:0] out4_q[$];

  // Record every output transfer of the p_len=4 instance just before the edge.
  always @(negedge clk) begin
    #4;
    if (!reset && if4.ostream_val && if4.ostream_rdy) begin
      out4_cnt++;
      out4_q.push_back(if4.ostream_msg);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Offer one product to the p_len=4 instance after some idle cycles.
  task automatic put4(input logic [31:0] v, input int gaps);
    int t;
    t = 0;
    repeat (gaps) begin
      @(negedge clk);
      if4.istream_val = 1'b0;
    end
    @(negedge clk);
    if4.istream_val = 1'b1;
    if4.istream_msg = v;
    while (!if4.istream_rdy && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) chk("istream_rdy_timeout", {31'b0, if4.istream_rdy}, 32'd1);
    @(posedge clk);
  endtask

  // Cycle right after the last handshake of a group: sum must be presented.
  task automatic group_check(input logic [31:0] exp, input string nm);
    @(negedge clk);
    chk({nm, "_oval"}, {31'b0, if4.ostream_val}, 32'd1);
    chk({nm, "_omsg"}, if4.ostream_msg, exp);
    chk({nm, "_irdy"}, {31'b0, if4.istream_rdy}, 32'd0);
    if4.istream_val = 1'b0;
  endtask

  initial begin
    vec_t        tbl[5];
    logic [31:0] p1[3];
    int          base;
    int          found;

    tbl[0] = '{din: '{32'd4, 32'd3, 32'd2, 32'd1},                  exp: 32'h0000000a, gaps: 1'b0, name: "g_1234"};
    tbl[1] = '{din: '{32'd40, 32'd30, 32'd20, 32'd10},              exp: 32'h00000064, gaps: 1'b0, name: "g_10_40"};
    tbl[2] = '{din: '{32'd3, 32'd2, 32'd1, 32'hffffffff},           exp: 32'h00000005, gaps: 1'b0, name: "g_wrap"};
    tbl[3] = '{din: '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000},
               exp: 32'h00000000, gaps: 1'b0, name: "g_wrap0"};
    tbl[4] = '{din: '{32'd1, 32'd0, 32'd0, 32'd7},                  exp: 32'h00000008, gaps: 1'b1, name: "g_bubbles"};
    p1[0] = 32'h7;
    p1[1] = 32'h9;
    p1[2] = 32'hdeadbeef;

    if4.istream_val = 1'b0;
    if4.istream_msg = '0;
    if4.ostream_rdy = 1'b1;
    if1.istream_val = 1'b0;
    if1.istream_msg = '0;
    if1.ostream_rdy = 1'b1;

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_oval4", {31'b0, if4.ostream_val}, 32'd0);
    chk("rst_omsg4", if4.ostream_msg, 32'd0);
    chk("rst_oval1", {31'b0, if1.ostream_val}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_irdy4", {31'b0, if4.istream_rdy}, 32'd1);
    chk("rst_irdy1", {31'b0, if1.istream_rdy}, 32'd1);

    // Table of groups, sink always ready
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) begin
        put4(tbl[i].din[j], tbl[i].gaps ? int'($urandom_range(3, 0)) : 0);
      end
      group_check(tbl[i].exp, tbl[i].name);
    end

    // Sink backpressure for 5 cycles
    @(negedge clk);
    if4.ostream_rdy = 1'b0;
    put4(32'd1, 0);
    put4(32'd2, 0);
    put4(32'd3, 0);
    put4(32'd4, 0);
    group_check(32'h0000000a, "bp_c1");
    base = out4_cnt;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_oval", {31'b0, if4.ostream_val}, 32'd1);
      chk("bp_omsg", if4.ostream_msg, 32'h0000000a);
      chk("bp_irdy", {31'b0, if4.istream_rdy}, 32'd0);
    end
    @(negedge clk);
    if4.ostream_rdy = 1'b1;
    @(negedge clk);
    chk("bp_after_oval", {31'b0, if4.ostream_val}, 32'd0);
    chk("bp_one_xfer", out4_cnt - base, 32'd1);

    // Reset in the middle of a group discards 5+6
    put4(32'd5, 0);
    put4(32'd6, 0);
    @(negedge clk);
    if4.istream_val = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_irdy", {31'b0, if4.istream_rdy}, 32'd1);
    chk("mr_oval", {31'b0, if4.ostream_val}, 32'd0);
    chk("mr_omsg", if4.ostream_msg, 32'd0);
    for (int j = 0; j < 4; j++) put4(32'd5, 0);
    group_check(32'h00000014, "mr_group");
    @(negedge clk);
    @(negedge clk);
    chk("out4_count", out4_cnt, 32'd7);
    found = 0;
    foreach (out4_q[k]) if (out4_q[k] == 32'd11) found++;
    chk("no_partial_sum", found, 32'd0);
    chk("last_out", (out4_q.size() > 0) ? out4_q[$] : 32'hxxxxxxxx, 32'h00000014);

    // p_len=1 pass-through, one cycle after each handshake
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("p1_in_irdy", {31'b0, if1.istream_rdy}, 32'd1);
      chk("p1_in_oval", {31'b0, if1.ostream_val}, 32'd0);
      if1.istream_val = 1'b1;
      if1.istream_msg = p1[i];
      @(posedge clk);
      @(negedge clk);
      chk("p1_oval", {31'b0, if1.ostream_val}, 32'd1);
      chk("p1_omsg", if1.ostream_msg, p1[i]);
      chk("p1_irdy", {31'b0, if1.istream_rdy}, 32'd0);
      if1.istream_val = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
